// File: rtl/b01p_serial_adder_pkg.sv
// Shared types and helpers for the b01p bit-serial adder/subtractor.
package b01p_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Width of the bit counter; never narrower than one bit.
  function automatic int cnt_width(input int word_len);
    return (word_len <= 2) ? 1 : $clog2(word_len);
  endfunction

endpackage

// File: rtl/b01p_serial_adder_if.sv
// Serial operand/result bundle between the line receivers and b01p_serial_adder.
interface b01p_serial_adder_if #(
  parameter int LANES = 4
);

  logic [LANES-1:0] LINE1;
  logic [LANES-1:0] LINE2;
  logic             IN_VALID;
  logic             SUB;
  logic             ABORT;
  logic [LANES-1:0] OUTP_REG;
  logic             OUT_VALID;
  logic             LAST_REG;
  logic [LANES-1:0] OVERFLW_REG;

  modport master (
    output LINE1, LINE2, IN_VALID, SUB, ABORT,
    input  OUTP_REG, OUT_VALID, LAST_REG, OVERFLW_REG
  );

  modport slave (
    input  LINE1, LINE2, IN_VALID, SUB, ABORT,
    output OUTP_REG, OUT_VALID, LAST_REG, OVERFLW_REG
  );

endinterface

// File: rtl/b01p_serial_adder_lane.sv
// One serial full adder/subtractor lane with carry, result and overflow registers.
// B01P_SIGNED_OVF_EN selects two's-complement overflow instead of carry/borrow.
module b01p_lane
  import b01p_pkg::*;
(
  input  logic clock,
  input  logic nRESET_G,
  input  logic a,
  input  logic b,
  input  logic mode,
  input  logic first,
  input  logic en,
  input  logic clr,
  input  logic last,
  output logic outp_reg,
  output logic ovf_reg
);

  logic carry_q, carry_d;
  logic outp_q, outp_d;
  logic ovf_q, ovf_d;
  logic b_eff, cin, sum, cout, ovf_bit;

  always_comb begin
    b_eff = b ^ mode;
    // Bit 0 takes its carry-in from the mode so subtract becomes A + ~B + 1.
    cin   = first ? (mode == MODE_SUB) : carry_q;
    sum   = a ^ b_eff ^ cin;
    cout  = (a & b_eff) | (a & cin) | (b_eff & cin);
`ifdef B01P_SIGNED_OVF_EN
    ovf_bit = cin ^ cout;
`else
    ovf_bit = (mode == MODE_SUB) ? ~cout : cout;
`endif

    carry_d = carry_q;
    if (clr) begin
      carry_d = 1'b0;
    end else if (en) begin
      carry_d = last ? 1'b0 : cout;
    end

    outp_d = en & sum;
    ovf_d  = en & last & ovf_bit;
  end

  always_ff @(posedge clock) begin
    if (!nRESET_G) begin
      carry_q <= 1'b0;
      outp_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      carry_q <= carry_d;
      outp_q  <= outp_d;
      ovf_q   <= ovf_d;
    end
  end

  assign outp_reg = outp_q;
  assign ovf_reg  = ovf_q;

endmodule

// File: rtl/b01p_serial_adder.sv
// LANES-wide bit-serial adder/subtractor: word FSM, bit counter, mode latch and framing.
// B01P_SIGNED_OVF_EN (in b01p_lane) switches the overflow rule to signed.
module b01p_serial_adder
  import b01p_pkg::*;
#(
  parameter int WORD_LEN = 8,
  parameter int LANES    = 4
) (
  input  logic                 clock,
  input  logic                 nRESET_G,
  b01p_serial_adder_if.slave   bus
);

  localparam int            CW       = cnt_width(WORD_LEN);
  localparam logic [CW-1:0] LAST_CNT = CW'(WORD_LEN - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mode_q, mode_d;
  logic          out_valid_q, out_valid_d;
  logic          last_q, last_d;
  logic          fire, is_first, is_last, mode_eff;

  always_comb begin
    fire     = bus.IN_VALID & ~bus.ABORT;
    is_first = (state_q == ST_IDLE);
    is_last  = (state_q == ST_RUN) && (cnt_q == LAST_CNT);
    // The word's mode is taken live from SUB on bit 0 and from mode_q afterwards.
    mode_eff = is_first ? bus.SUB : mode_q;

    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;

    if (bus.ABORT) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      mode_d  = MODE_ADD;
    end else if (bus.IN_VALID) begin
      case (state_q)
        ST_IDLE: begin
          mode_d  = bus.SUB;
          cnt_d   = CW'(1);
          state_d = ST_RUN;
        end
        ST_RUN: begin
          if (is_last) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    out_valid_d = fire;
    last_d      = fire & is_last;
  end

  always_ff @(posedge clock) begin
    if (!nRESET_G) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mode_q      <= MODE_ADD;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    b01p_lane u_lane (
      .clock    (clock),
      .nRESET_G (nRESET_G),
      .a        (bus.LINE1[g]),
      .b        (bus.LINE2[g]),
      .mode     (mode_eff),
      .first    (is_first),
      .en       (fire),
      .clr      (bus.ABORT),
      .last     (is_last),
      .outp_reg (bus.OUTP_REG[g]),
      .ovf_reg  (bus.OVERFLW_REG[g])
    );
  end

  assign bus.OUT_VALID = out_valid_q;
  assign bus.LAST_REG  = last_q;

endmodule

// File: tb/tb_b01p_serial_adder.sv
// Self-checking bench for b01p_serial_adder (WORD_LEN=8, LANES=2) with a timed scoreboard.
module tb_b01p_serial_adder;

  typedef struct {
    logic [7:0] a0, b0, a1, b1;
    logic       sub;
    logic [7:0] s0, s1;
    logic [1:0] ovf;
  } vec_t;

  typedef struct {
    int         tag;
    logic [1:0] outp;
    logic       last;
    logic [1:0] ovf;
  } exp_t;

  logic clock;
  logic nreset_g;
  int   cyc;
  int   n_cmp;
  int   n_err;
  bit   mon_en;
  exp_t q[$];
  exp_t mon_e;
  logic mon_valid;
  vec_t vecs[6];

  b01p_serial_adder_if #(.LANES(2)) bus ();

  b01p_serial_adder #(.WORD_LEN(8), .LANES(2)) dut (
    .clock    (clock),
    .nRESET_G (nreset_g),
    .bus      (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [1:0] l1, input logic [1:0] l2, input logic valid,
                                input logic sub, input logic abort, input logic rst_n,
                                input logic push, input logic [1:0] e_out, input logic e_last,
                                input logic [1:0] e_ovf);
    exp_t e;
    bus.LINE1    = l1;
    bus.LINE2    = l2;
    bus.IN_VALID = valid;
    bus.SUB      = sub;
    bus.ABORT    = abort;
    nreset_g     = rst_n;
    @(posedge clock);
    #1;
    if (push) begin
      e.tag  = cyc;
      e.outp = e_out;
      e.last = e_last;
      e.ovf  = e_ovf;
      q.push_back(e);
    end
  endtask

  task automatic send_word(input vec_t v, input int gap_after, input int gap_len,
                           input int abort_at, input int reset_at, input bit toggle_sub);
    for (int i = 0; i < 8; i++) begin
      logic [1:0] l1, l2;
      logic       s;
      l1 = {v.a1[i], v.a0[i]};
      l2 = {v.b1[i], v.b0[i]};
      s  = (toggle_sub && i > 0) ? 1'($urandom_range(0, 1)) : v.sub;
      if (i == abort_at) begin
        apply_stimulus(l1, l2, 1'b1, s, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00);
        return;
      end
      if (i == reset_at) begin
        apply_stimulus(l1, l2, 1'b1, s, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00);
        return;
      end
      apply_stimulus(l1, l2, 1'b1, s, 1'b0, 1'b1, 1'b1, {v.s1[i], v.s0[i]},
                     (i == 7), (i == 7) ? v.ovf : 2'b00);
      if (i == gap_after) begin
        repeat (gap_len)
          apply_stimulus(2'($urandom), 2'($urandom), 1'b0, 1'($urandom), 1'b0, 1'b1,
                         1'b0, 2'b00, 1'b0, 2'b00);
      end
    end
  endtask

  // Each output cycle must match the bit whose expected cycle tag is due now.
  always @(negedge clock) begin
    if (mon_en) begin
      while (q.size() > 0 && q[0].tag < cyc) begin
        mon_e = q.pop_front();
        n_cmp++;
        n_err++;
        $display("[TB] FAIL missed_bit: expected output at cycle %0d, got none (now %0d)", mon_e.tag, cyc);
      end
      mon_valid = (q.size() > 0 && q[0].tag == cyc);
      check_output("out_valid", 32'(bus.OUT_VALID), 32'(mon_valid));
      if (mon_valid) begin
        mon_e = q.pop_front();
        check_output("outp_reg", 32'(bus.OUTP_REG), 32'(mon_e.outp));
        check_output("last_reg", 32'(bus.LAST_REG), 32'(mon_e.last));
        check_output("overflw_reg", 32'(bus.OVERFLW_REG), 32'(mon_e.ovf));
      end else begin
        check_output("idle_last_reg", 32'(bus.LAST_REG), 32'd0);
        check_output("idle_overflw_reg", 32'(bus.OVERFLW_REG), 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
`ifdef B01P_SIGNED_OVF_EN
    vecs[0] = '{8'h35, 8'h0A, 8'h01, 8'h01, 1'b0, 8'h3F, 8'h02, 2'b00};
    vecs[1] = '{8'hFF, 8'h01, 8'h7F, 8'h01, 1'b0, 8'h00, 8'h80, 2'b10};
    vecs[2] = '{8'h10, 8'h20, 8'h20, 8'h10, 1'b1, 8'hF0, 8'h10, 2'b00};
    vecs[3] = '{8'h80, 8'h80, 8'h40, 8'h40, 1'b0, 8'h00, 8'h80, 2'b11};
    vecs[4] = '{8'h80, 8'h01, 8'h00, 8'h01, 1'b1, 8'h7F, 8'hFF, 2'b01};
    vecs[5] = '{8'hA5, 8'h5A, 8'h05, 8'h05, 1'b1, 8'h4B, 8'h00, 2'b01};
`else
    vecs[0] = '{8'h35, 8'h0A, 8'h01, 8'h01, 1'b0, 8'h3F, 8'h02, 2'b00};
    vecs[1] = '{8'hFF, 8'h01, 8'h7F, 8'h01, 1'b0, 8'h00, 8'h80, 2'b01};
    vecs[2] = '{8'h10, 8'h20, 8'h20, 8'h10, 1'b1, 8'hF0, 8'h10, 2'b01};
    vecs[3] = '{8'h80, 8'h80, 8'h40, 8'h40, 1'b0, 8'h00, 8'h80, 2'b01};
    vecs[4] = '{8'h80, 8'h01, 8'h00, 8'h01, 1'b1, 8'h7F, 8'hFF, 2'b10};
    vecs[5] = '{8'hA5, 8'h5A, 8'h05, 8'h05, 1'b1, 8'h4B, 8'h00, 2'b00};
`endif

    cyc    = 0;
    n_cmp  = 0;
    n_err  = 0;
    mon_en = 1'b0;

    repeat (3) apply_stimulus(2'b11, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00);
    check_output("reset_outp_reg", 32'(bus.OUTP_REG), 32'd0);
    check_output("reset_out_valid", 32'(bus.OUT_VALID), 32'd0);
    check_output("reset_last_reg", 32'(bus.LAST_REG), 32'd0);
    check_output("reset_overflw_reg", 32'(bus.OVERFLW_REG), 32'd0);
    mon_en = 1'b1;
    apply_stimulus(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00);

    $display("[TB] table vectors, back-to-back");
    for (int k = 0; k < 6; k++) send_word(vecs[k], -1, 0, -1, -1, 1'b0);
    apply_stimulus(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00);

    $display("[TB] subtract with SUB toggling mid-word");
    send_word(vecs[2], -1, 0, -1, -1, 1'b1);
    send_word(vecs[0], -1, 0, -1, -1, 1'b1);

    $display("[TB] three-cycle gap after bit 3");
    send_word(vecs[0], 3, 3, -1, -1, 1'b0);

    $display("[TB] abort at bit 5 then fresh word");
    send_word(vecs[4], -1, 0, 5, -1, 1'b0);
    send_word(vecs[0], -1, 0, -1, -1, 1'b0);

    $display("[TB] reset at bit 4 then full word");
    send_word(vecs[1], -1, 0, -1, 4, 1'b0);
    check_output("midreset_outp_reg", 32'(bus.OUTP_REG), 32'd0);
    check_output("midreset_out_valid", 32'(bus.OUT_VALID), 32'd0);
    send_word(vecs[0], -1, 0, -1, -1, 1'b0);

    repeat (4) apply_stimulus(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00);
    check_output("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
